// File: rtl/text_scan_reader.sv
// Character-cell scan-out: pixel counters -> display RAM read -> font ROM read -> palette RGB.
// Latency: RGB, hsync_o and vsync_o all appear exactly 3 clk after the pixel counters.
// Backpressure: none; one RAM read per active pixel every clock, RAM and ROM are fixed 1-cycle.
module text_scan_reader #(
   parameter int BLINK_EN     = 0,
   parameter int BLINK_FRAMES = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [9:0]  hcount,
   input  logic [9:0]  vcount,
   input  logic        video_on,
   input  logic        hsync_in,
   input  logic        vsync_in,
   output logic [12:0] raddr,
   output logic        rd,
   input  logic [15:0] rdata,
   output logic [11:0] font_addr,
   input  logic [7:0]  font_data,
   output logic [3:0]  vga_r,
   output logic [3:0]  vga_g,
   output logic [3:0]  vga_b,
   output logic        hsync_o,
   output logic        vsync_o,
   output logic [7:0]  frame_cnt
);

   localparam logic [7:0] BLINK_DIV = BLINK_FRAMES[7:0];

   // S0 state: pixel position within the glyph and the sync/active flags
   logic [2:0] s0_px;
   logic [3:0] s0_line;
   logic       s0_act;
   logic       s0_hs;
   logic       s0_vs;

   // S1 state: attribute byte rides alongside the font ROM lookup
   logic [7:0] s1_attr;
   logic [2:0] s1_px;
   logic       s1_act;
   logic       s1_hs;
   logic       s1_vs;

   logic       vs_hist;
   logic       act_in;
   logic [7:0] blink_quot;
   logic       blink_phase;
   logic [3:0] fg;
   logic [3:0] bg;
   logic [3:0] ci;
   logic       pix_bit;
   logic [11:0] rgb_nxt;

   // CGA palette: each set channel is 0xA, plus 0x5 when intensity is set; colour 6 is brown
   function automatic logic [11:0] palette(input logic [3:0] idx);
      logic [3:0] on_lvl;
      logic [3:0] off_lvl;
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
      on_lvl  = idx[3] ? 4'hF : 4'hA;
      off_lvl = idx[3] ? 4'h5 : 4'h0;
      r = idx[2] ? on_lvl : off_lvl;
      g = idx[1] ? on_lvl : off_lvl;
      b = idx[0] ? on_lvl : off_lvl;
      if (idx == 4'h6) g = 4'h5;
      return {r, g, b};
   endfunction

   // Only the 512x480 text area fetches cells; everything else is blank
   assign act_in = video_on & (hcount < 10'd512) & (vcount < 10'd480);

   // S0: issue the character RAM read and register pixel context
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         raddr   <= '0;
         rd      <= 1'b0;
         s0_px   <= '0;
         s0_line <= '0;
         s0_act  <= 1'b0;
         s0_hs   <= 1'b1;
         s0_vs   <= 1'b1;
      end else begin
         raddr   <= {2'b00, vcount[8:4], hcount[8:3]};
         rd      <= act_in;
         s0_px   <= hcount[2:0];
         s0_line <= vcount[3:0];
         s0_act  <= act_in;
         s0_hs   <= hsync_in;
         s0_vs   <= vsync_in;
      end
   end

   // S1: turn the character code into a font ROM row address
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         font_addr <= '0;
         s1_attr   <= '0;
         s1_px     <= '0;
         s1_act    <= 1'b0;
         s1_hs     <= 1'b1;
         s1_vs     <= 1'b1;
      end else begin
         font_addr <= {rdata[7:0], s0_line};
         s1_attr   <= rdata[15:8];
         s1_px     <= s0_px;
         s1_act    <= s0_act;
         s1_hs     <= s0_hs;
         s1_vs     <= s0_vs;
      end
   end

   assign blink_quot  = frame_cnt / BLINK_DIV;
   assign blink_phase = blink_quot[0];

   // S2 colour select: glyph bit chooses fg or bg; blinking cells hide fg in the odd half
   always_comb begin
      bg = (BLINK_EN != 0) ? {1'b0, s1_attr[6:4]} : s1_attr[7:4];
      fg = s1_attr[3:0];
      if ((BLINK_EN != 0) && s1_attr[7] && blink_phase) fg = bg;
      pix_bit = font_data[3'd7 - s1_px];
      ci      = pix_bit ? fg : bg;
      rgb_nxt = s1_act ? palette(ci) : 12'h000;
   end

   // S2: register RGB together with the delayed syncs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vga_r   <= '0;
         vga_g   <= '0;
         vga_b   <= '0;
         hsync_o <= 1'b1;
         vsync_o <= 1'b1;
      end else begin
         {vga_r, vga_g, vga_b} <= rgb_nxt;
         hsync_o <= s1_hs;
         vsync_o <= s1_vs;
      end
   end

   // Frame counter: count vsync falling edges, free-running with natural 8-bit wrap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_hist   <= 1'b1;
         frame_cnt <= '0;
      end else begin
         vs_hist <= vsync_in;
         if (vs_hist && !vsync_in) frame_cnt <= frame_cnt + 8'd1;
      end
   end

endmodule
